// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit
package fetch_pkg;
  typedef enum logic [1:0] {ISSUE, WAIT, KILL} fetch_state_t;
  localparam int PC_INCR = 4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: memory, redirect and decode-side signals of the fetch unit
interface instr_fetch_unit_if #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 32);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count, registered head
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (rst) mem <= '{default: '0};
    else if (push) mem[wr_ptr] <= din;
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generation, req/ack instruction fetch and buffering with redirect flush
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DATA_WIDTH = 32,
  parameter int              ADDR_WIDTH = 32,
  parameter logic [31:0]     RESET_PC   = 32'h0,
  parameter int              FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_n, req_addr;
  logic [CW-1:0] count;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;
  logic push, pop, flush, valid, slot_after;
  assign flush      = bus.redirect_valid;
  assign valid      = count != '0;
  assign pop        = valid && bus.instr_ready;
  assign push       = state == WAIT && bus.imem_ack && !flush;
  // the request issued after an ack needs its own reserved slot
  assign slot_after = (count + CW'(1) - CW'(pop)) < CW'(FIFO_DEPTH);
  assign fetch_pc_n = flush ? {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00} :
                      push  ? fetch_pc + ADDR_WIDTH'(PC_INCR) : fetch_pc;
  always_comb begin
    state_n = state;
    case (state)
      ISSUE:   state_n = (flush || count < CW'(FIFO_DEPTH)) ? WAIT : ISSUE;
      WAIT:    state_n = !bus.imem_ack ? (flush ? KILL : WAIT) : (flush || slot_after) ? WAIT : ISSUE;
      KILL:    state_n = !bus.imem_ack ? KILL : flush ? WAIT : ISSUE;
      default: state_n = ISSUE;
    endcase
  end
  // a killed request keeps its original address until it is acked
  always_ff @(posedge clk)
    if (rst) begin
      state    <= ISSUE;
      fetch_pc <= ADDR_WIDTH'(RESET_PC);
      req_addr <= ADDR_WIDTH'(RESET_PC);
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      if (state_n != KILL) req_addr <= fetch_pc_n;
    end
  fetch_fifo #(.WIDTH(ADDR_WIDTH + DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({fetch_pc, bus.imem_rdata}),
    .dout  (head),
    .count (count)
  );
  assign bus.imem_req    = state != ISSUE;
  assign bus.imem_addr   = req_addr;
  assign bus.instr_valid = valid;
  assign {bus.instr_pc, bus.instr} = head;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenario checks of the fetch unit with a simple memory model
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst5 = 1'b1;
  int total = 0;
  int passed = 0;
  int acks;
  instr_fetch_unit_if bus ();
  instr_fetch_unit_if bus5 ();
  instr_fetch_unit #(.RESET_PC(32'h0)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut5 (.clk(clk), .rst(rst5), .bus(bus5));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction
  task automatic drive(input logic a, input logic r);
    bus.imem_ack = a & bus.imem_req;
    bus.imem_rdata = mem_fn(bus.imem_addr);
    bus.instr_ready = r;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    @(negedge clk);
  endtask
  task automatic drive5(input logic a, input logic r);
    bus5.imem_ack = a & bus5.imem_req;
    bus5.imem_rdata = mem_fn(bus5.imem_addr);
    bus5.instr_ready = r;
    bus5.redirect_valid = 1'b0;
    bus5.redirect_pc = '0;
    @(negedge clk);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    drive(0, 0);
    drive(0, 0);
    rst = 1'b0;
  endtask
  task automatic test_reset;
    do_reset;
    rst = 1'b1;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req got %0h exp 0", bus.imem_req); else passed++;
    total++; if (bus.imem_addr !== 32'h0) $display("FAIL reset_addr got %0h exp 0", bus.imem_addr); else passed++;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid got %0h exp 0", bus.instr_valid); else passed++;
    total++; if (bus.instr !== 32'h0) $display("FAIL reset_instr got %0h exp 0", bus.instr); else passed++;
    total++; if (bus.instr_pc !== 32'h0) $display("FAIL reset_instr_pc got %0h exp 0", bus.instr_pc); else passed++;
    total++; if (bus5.imem_addr !== 32'hFFFF_FFFC) $display("FAIL reset5_addr got %0h exp fffffffc", bus5.imem_addr); else passed++;
    total++; if (bus5.imem_req !== 1'b0) $display("FAIL reset5_req got %0h exp 0", bus5.imem_req); else passed++;
  endtask
  task automatic test_stream;
    do_reset;
    drive(1, 1);
    total++; if (bus.imem_req !== 1'b1) $display("FAIL stream_req got %0h exp 1", bus.imem_req); else passed++;
    total++; if (bus.imem_addr !== 32'h0) $display("FAIL stream_addr0 got %0h exp 0", bus.imem_addr); else passed++;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL stream_valid0 got %0h exp 0", bus.instr_valid); else passed++;
    drive(1, 1);
    total++; if (bus.imem_addr !== 32'h4) $display("FAIL stream_addr4 got %0h exp 4", bus.imem_addr); else passed++;
    total++; if (bus.instr_valid !== 1'b1) $display("FAIL stream_valid1 got %0h exp 1", bus.instr_valid); else passed++;
    total++; if (bus.instr_pc !== 32'h0) $display("FAIL stream_pc0 got %0h exp 0", bus.instr_pc); else passed++;
    total++; if (bus.instr !== mem_fn(32'h0)) $display("FAIL stream_instr0 got %0h exp %0h", bus.instr, mem_fn(32'h0)); else passed++;
    drive(1, 1);
    total++; if (bus.imem_addr !== 32'h8) $display("FAIL stream_addr8 got %0h exp 8", bus.imem_addr); else passed++;
    total++; if (bus.instr_pc !== 32'h4) $display("FAIL stream_pc4 got %0h exp 4", bus.instr_pc); else passed++;
    drive(1, 1);
    total++; if (bus.imem_addr !== 32'hC) $display("FAIL stream_addrc got %0h exp c", bus.imem_addr); else passed++;
    total++; if (bus.instr_pc !== 32'h8) $display("FAIL stream_pc8 got %0h exp 8", bus.instr_pc); else passed++;
    total++; if (bus.instr !== mem_fn(32'h8)) $display("FAIL stream_instr8 got %0h exp %0h", bus.instr, mem_fn(32'h8)); else passed++;
  endtask
  task automatic test_backpressure;
    do_reset;
    acks = 0;
    // memory acks every cycle regardless of req; stray acks must be ignored
    for (int i = 0; i < 10; i++) begin
      bus.imem_ack = 1'b1;
      bus.imem_rdata = mem_fn(bus.imem_addr);
      bus.instr_ready = 1'b0;
      if (bus.imem_req) acks++;
      @(negedge clk);
    end
    total++; if (acks !== 2) $display("FAIL bp_acks got %0d exp 2", acks); else passed++;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL bp_req got %0h exp 0", bus.imem_req); else passed++;
    total++; if (bus.instr_pc !== 32'h0) $display("FAIL bp_hold_pc got %0h exp 0", bus.instr_pc); else passed++;
    total++; if (bus.instr_valid !== 1'b1) $display("FAIL bp_valid got %0h exp 1", bus.instr_valid); else passed++;
    drive(0, 1);
    total++; if (bus.instr_pc !== 32'h4) $display("FAIL bp_drain_pc got %0h exp 4", bus.instr_pc); else passed++;
    total++; if (bus.instr !== mem_fn(32'h4)) $display("FAIL bp_drain_instr got %0h exp %0h", bus.instr, mem_fn(32'h4)); else passed++;
    drive(0, 1);
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL bp_empty got %0h exp 0", bus.instr_valid); else passed++;
    total++; if (bus.imem_req !== 1'b1) $display("FAIL bp_resume_req got %0h exp 1", bus.imem_req); else passed++;
    total++; if (bus.imem_addr !== 32'h8) $display("FAIL bp_resume_addr got %0h exp 8", bus.imem_addr); else passed++;
    drive(1, 1);
    total++; if (bus.instr_pc !== 32'h8) $display("FAIL bp_resume_pc got %0h exp 8", bus.instr_pc); else passed++;
  endtask
  task automatic test_redirect_inflight;
    do_reset;
    drive(1, 1);
    drive(1, 1);
    drive(1, 1);
    bus.imem_ack = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL ri_flush got %0h exp 0", bus.instr_valid); else passed++;
    total++; if (bus.imem_req !== 1'b1) $display("FAIL ri_req_held got %0h exp 1", bus.imem_req); else passed++;
    total++; if (bus.imem_addr !== 32'h8) $display("FAIL ri_addr_stable got %0h exp 8", bus.imem_addr); else passed++;
    drive(0, 1);
    drive(0, 1);
    drive(1, 1);
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL ri_drop got %0h exp 0", bus.instr_valid); else passed++;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL ri_idle got %0h exp 0", bus.imem_req); else passed++;
    drive(1, 1);
    total++; if (bus.imem_addr !== 32'h100) $display("FAIL ri_new_addr got %0h exp 100", bus.imem_addr); else passed++;
    drive(1, 1);
    total++; if (bus.instr_pc !== 32'h100) $display("FAIL ri_new_pc got %0h exp 100", bus.instr_pc); else passed++;
    total++; if (bus.instr !== mem_fn(32'h100)) $display("FAIL ri_new_instr got %0h exp %0h", bus.instr, mem_fn(32'h100)); else passed++;
  endtask
  task automatic test_redirect_ack;
    do_reset;
    drive(1, 1);
    drive(1, 1);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_fn(bus.imem_addr);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h203;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL ra_drop got %0h exp 0", bus.instr_valid); else passed++;
    total++; if (bus.imem_req !== 1'b1) $display("FAIL ra_req got %0h exp 1", bus.imem_req); else passed++;
    total++; if (bus.imem_addr !== 32'h200) $display("FAIL ra_addr got %0h exp 200", bus.imem_addr); else passed++;
    drive(1, 1);
    total++; if (bus.instr_pc !== 32'h200) $display("FAIL ra_pc got %0h exp 200", bus.instr_pc); else passed++;
  endtask
  task automatic test_pc_wrap;
    rst5 = 1'b0;
    drive5(1, 1);
    total++; if (bus5.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0 got %0h exp fffffffc", bus5.imem_addr); else passed++;
    drive5(1, 1);
    total++; if (bus5.instr_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0 got %0h exp fffffffc", bus5.instr_pc); else passed++;
    total++; if (bus5.imem_addr !== 32'h0) $display("FAIL wrap_addr1 got %0h exp 0", bus5.imem_addr); else passed++;
    drive5(1, 1);
    total++; if (bus5.instr_pc !== 32'h0) $display("FAIL wrap_pc1 got %0h exp 0", bus5.instr_pc); else passed++;
    total++; if (bus5.instr !== mem_fn(32'h0)) $display("FAIL wrap_instr1 got %0h exp %0h", bus5.instr, mem_fn(32'h0)); else passed++;
  endtask
  task automatic test_rst_midtxn;
    do_reset;
    drive(1, 1);
    drive(1, 1);
    rst = 1'b1;
    drive(0, 1);
    total++; if (bus.imem_req !== 1'b0) $display("FAIL mr_req got %0h exp 0", bus.imem_req); else passed++;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL mr_valid got %0h exp 0", bus.instr_valid); else passed++;
    rst = 1'b0;
    drive(1, 1);
    total++; if (bus.imem_req !== 1'b1) $display("FAIL mr_restart_req got %0h exp 1", bus.imem_req); else passed++;
    total++; if (bus.imem_addr !== 32'h0) $display("FAIL mr_restart_addr got %0h exp 0", bus.imem_addr); else passed++;
  endtask
  initial begin
    bus5.imem_ack = 1'b0;
    bus5.imem_rdata = '0;
    bus5.instr_ready = 1'b0;
    bus5.redirect_valid = 1'b0;
    bus5.redirect_pc = '0;
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_inflight;
    test_redirect_ack;
    test_pc_wrap;
    test_rst_midtxn;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
